// File: rtl/tomasula_types.sv
// Shared dispatch types for the Tomasulo front end: instruction/station words, CDB
// entries and the operand lookup/snoop helpers used by the dispatcher.
package tomasula_types;

  localparam int unsigned NUM_TAGS = 8;
  localparam int unsigned XLEN     = 32;

  typedef logic [2:0] rob_tag_t;

  typedef enum logic [2:0] {
    BRANCH  = 3'd0,
    ALU_REG = 3'd1,
    ALU_IMM = 3'd2,
    LOAD    = 3'd3,
    STORE   = 3'd4,
    JAL     = 3'd5,
    JALR    = 3'd6,
    LUI     = 3'd7
  } op_e;

  typedef struct packed {
    op_e             op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
  } dispatch_word;

  typedef struct packed {
    logic [XLEN-1:0] data;
  } cdb_data;

  typedef struct packed {
    op_e             op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            use_imm;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    rob_tag_t        rd_tag;
    logic            src1_valid;
    rob_tag_t        src1_tag;
    logic [XLEN-1:0] src1_data;
    logic            src2_valid;
    rob_tag_t        src2_tag;
    logic [XLEN-1:0] src2_data;
  } res_word;

  // One source operand as held by a station.
  typedef struct packed {
    logic            valid;
    rob_tag_t        tag;
    logic [XLEN-1:0] data;
  } src_t;

  // Resolve a source from the register-status lookup; x0 always reads as a valid zero.
  function automatic src_t lookup_src(input logic [4:0] idx, input logic ready,
                                      input rob_tag_t tag, input logic [XLEN-1:0] data,
                                      input logic [NUM_TAGS-1:0] calc,
                                      input cdb_data [NUM_TAGS-1:0] cdb);
    src_t s;
    s.valid = 1'b0;
    s.tag   = tag;
    s.data  = '0;
    if (idx == 5'd0) begin
      s.valid = 1'b1;
      s.tag   = '0;
    end else if (ready) begin
      s.valid = 1'b1;
      s.tag   = '0;
      s.data  = data;
    end else if (calc[tag]) begin
      s.valid = 1'b1;
      s.data  = cdb[tag].data;
    end
    return s;
  endfunction

  // Pick up a result for a still-pending source once its producer has completed.
  function automatic src_t snoop_src(input src_t s, input logic [NUM_TAGS-1:0] calc,
                                     input cdb_data [NUM_TAGS-1:0] cdb);
    src_t r;
    r = s;
    if (!s.valid && calc[s.tag]) begin
      r.valid = 1'b1;
      r.data  = cdb[s.tag].data;
    end
    return r;
  endfunction

endpackage

// File: rtl/res_dispatch_if.sv
// Dispatcher bus: instruction queue, ROB allocation, register-status lookup,
// CDB snoop inputs and reservation-station write port.
interface res_dispatch_if
  import tomasula_types::*;
#(
  parameter int unsigned NUM_RS = 4
) ();

  logic                  iq_valid;
  logic                  iq_ready;
  dispatch_word          iq_word;
  logic                  rob_alloc_req;
  logic                  rob_alloc_ack;
  rob_tag_t              rob_tag;
  logic [4:0]            rs1_idx;
  logic [4:0]            rs2_idx;
  logic                  rs1_ready;
  logic                  rs2_ready;
  rob_tag_t              rs1_tag;
  rob_tag_t              rs2_tag;
  logic [XLEN-1:0]       rs1_data;
  logic [XLEN-1:0]       rs2_data;
  logic [NUM_TAGS-1:0]   robs_calculated;
  cdb_data [NUM_TAGS-1:0] cdb;
  logic [NUM_RS-1:0]     res_empty;
  logic [NUM_RS-1:0]     load_word;
  res_word               res_out;

  // Environment side: queue, ROB, register status, CDB and stations.
  modport master (
    output iq_valid, iq_word, rob_alloc_ack, rob_tag, rs1_ready, rs2_ready, rs1_tag,
           rs2_tag, rs1_data, rs2_data, robs_calculated, cdb, res_empty,
    input  iq_ready, rob_alloc_req, rs1_idx, rs2_idx, load_word, res_out
  );

  // Dispatcher side.
  modport slave (
    input  iq_valid, iq_word, rob_alloc_ack, rob_tag, rs1_ready, rs2_ready, rs1_tag,
           rs2_tag, rs1_data, rs2_data, robs_calculated, cdb, res_empty,
    output iq_ready, rob_alloc_req, rs1_idx, rs2_idx, load_word, res_out
  );

endinterface

// File: rtl/rs_select.sv
// Lowest-index empty reservation station picker.
module rs_select #(
  parameter int unsigned NUM_RS = 4
) (
  input  logic [NUM_RS-1:0] res_empty,
  output logic [NUM_RS-1:0] one_hot,
  output logic              any
);

  // Isolate the lowest set bit (x & -x), which is one-hot by construction.
  always_comb begin
    one_hot = res_empty & (~res_empty + {{(NUM_RS-1){1'b0}}, 1'b1});
    any     = |res_empty;
  end

endmodule

// File: rtl/res_dispatch.sv
// Dispatcher: takes one decoded instruction, allocates a ROB entry, gathers its
// operands and writes it into the lowest-index free reservation station.
module res_dispatch
  import tomasula_types::*;
#(
  parameter int unsigned NUM_RS = 4
) (
  input logic          clk,
  input logic          rst,
  input logic          flush,
  res_dispatch_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ALLOC, OPER, ISSUE} state_e;

  state_e            st_q;
  res_word           res_q;
  res_word           res_new;
  res_word           res_snoop;
  logic [4:0]        rs1_q;
  logic [4:0]        rs2_q;
  src_t              src1_cap;
  src_t              src2_cap;
  src_t              src1_held;
  src_t              src2_held;
  src_t              src1_snp;
  src_t              src2_snp;
  logic [NUM_RS-1:0] sel_onehot;
  logic              sel_any;

  rs_select #(
    .NUM_RS(NUM_RS)
  ) u_rs_select (
    .res_empty(bus.res_empty),
    .one_hot  (sel_onehot),
    .any      (sel_any)
  );

  // Fresh station word from the incoming instruction; operands filled in later.
  always_comb begin
    res_new         = '0;
    res_new.op      = bus.iq_word.op;
    res_new.funct3  = bus.iq_word.funct3;
    res_new.funct7  = bus.iq_word.funct7;
    res_new.use_imm = bus.iq_word.use_imm;
    res_new.imm     = bus.iq_word.imm;
    res_new.pc      = bus.iq_word.pc;
  end

  // Operand capture from the register-status lookup; an immediate overrides rs2.
  always_comb begin
    src1_cap = lookup_src(rs1_q, bus.rs1_ready, bus.rs1_tag, bus.rs1_data,
                          bus.robs_calculated, bus.cdb);
    src2_cap = lookup_src(rs2_q, bus.rs2_ready, bus.rs2_tag, bus.rs2_data,
                          bus.robs_calculated, bus.cdb);
    if (res_q.use_imm) begin
      src2_cap = '{valid: 1'b1, tag: '0, data: res_q.imm};
    end
  end

  // Merge this cycle's CDB results into the held word so a strobe carries them.
  always_comb begin
    src1_held = '{valid: res_q.src1_valid, tag: res_q.src1_tag, data: res_q.src1_data};
    src2_held = '{valid: res_q.src2_valid, tag: res_q.src2_tag, data: res_q.src2_data};
    src1_snp  = snoop_src(src1_held, bus.robs_calculated, bus.cdb);
    src2_snp  = snoop_src(src2_held, bus.robs_calculated, bus.cdb);
    res_snoop            = res_q;
    res_snoop.src1_valid = src1_snp.valid;
    res_snoop.src1_data  = src1_snp.data;
    res_snoop.src2_valid = src2_snp.valid;
    res_snoop.src2_data  = src2_snp.data;
  end

  // Handshake outputs decode the state; flush and reset suppress them in their cycle.
  always_comb begin
    bus.iq_ready      = (st_q == IDLE) && !flush && !rst;
    bus.rob_alloc_req = (st_q == ALLOC) && !flush && !rst;
    bus.load_word     = ((st_q == ISSUE) && !flush && !rst) ? sel_onehot : '0;
    bus.rs1_idx       = rs1_q;
    bus.rs2_idx       = rs2_q;
    bus.res_out       = res_snoop;
  end

  // Dispatch FSM and held instruction state.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= IDLE;
      res_q <= '0;
      rs1_q <= '0;
      rs2_q <= '0;
    end else if (flush) begin
      st_q <= IDLE;
    end else begin
      unique case (st_q)
        IDLE: begin
          if (bus.iq_valid) begin
            res_q <= res_new;
            rs1_q <= bus.iq_word.rs1;
            rs2_q <= bus.iq_word.rs2;
            st_q  <= ALLOC;
          end
        end
        ALLOC: begin
          if (bus.rob_alloc_ack) begin
            res_q.rd_tag <= bus.rob_tag;
            st_q         <= OPER;
          end
        end
        OPER: begin
          res_q.src1_valid <= src1_cap.valid;
          res_q.src1_tag   <= src1_cap.tag;
          res_q.src1_data  <= src1_cap.data;
          res_q.src2_valid <= src2_cap.valid;
          res_q.src2_tag   <= src2_cap.tag;
          res_q.src2_data  <= src2_cap.data;
          st_q             <= ISSUE;
        end
        ISSUE: begin
          res_q <= res_snoop;
          if (sel_any) begin
            st_q <= IDLE;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_res_dispatch.sv
// Self-checking bench for res_dispatch: vector table with a scoreboard queue plus
// hand-written flush and reset sequences.
module tb_res_dispatch;
  import tomasula_types::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  res_dispatch_if #(.NUM_RS(4)) bus ();

  res_dispatch #(
    .NUM_RS(4)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        use_imm;
    logic [31:0] imm;
    logic        r1_rdy;
    logic [2:0]  r1_tag;
    logic [31:0] r1_data;
    logic        r2_rdy;
    logic [2:0]  r2_tag;
    logic [31:0] r2_data;
    logic [2:0]  rob_tag;
    logic [7:0]  calc;
    logic [7:0]  calc_cyc;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_val;
    logic [3:0]  empty;
    logic [7:0]  empty_cyc;
    logic [3:0]  exp_lw;
    logic [7:0]  exp_cyc;
    logic        e_s1v;
    logic [31:0] e_s1d;
    logic        e_s2v;
    logic [31:0] e_s2d;
  } vec_t;

  // Expected strobe; s1x/s2x hold data when valid, else the awaited tag.
  typedef struct {
    logic [3:0]  lw;
    logic [7:0]  cyc;
    logic [2:0]  tag;
    logic        s1v;
    logic [31:0] s1x;
    logic        s2v;
    logic [31:0] s2x;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush                   = 1'b0;
    bus.iq_valid            = 1'b0;
    bus.iq_word             = '0;
    bus.rob_alloc_ack       = 1'b0;
    bus.rob_tag             = '0;
    bus.rs1_ready           = 1'b0;
    bus.rs2_ready           = 1'b0;
    bus.rs1_tag             = '0;
    bus.rs2_tag             = '0;
    bus.rs1_data            = '0;
    bus.rs2_data            = '0;
    bus.robs_calculated     = '0;
    bus.res_empty           = '0;
    for (int t = 0; t < 8; t++) bus.cdb[t].data = 32'hDEAD_0000 | 32'(t);
  endtask

  task automatic set_word(input logic [4:0] rs1, input logic [4:0] rs2, input logic use_imm,
                          input logic [31:0] imm);
    bus.iq_word         = '0;
    bus.iq_word.op      = use_imm ? ALU_IMM : ALU_REG;
    bus.iq_word.rs1     = rs1;
    bus.iq_word.rs2     = rs2;
    bus.iq_word.use_imm = use_imm;
    bus.iq_word.imm     = imm;
    bus.iq_word.pc      = 32'h0000_0100;
  endtask

  task automatic check_strobe(input int c);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL unexpected_strobe: got %0h expected none", bus.load_word);
    end else begin
      e = sb_q.pop_front();
      chk("load_word", 32'(bus.load_word), 32'(e.lw));
      chk("strobe_cycle", 32'(c), 32'(e.cyc));
      chk("rd_tag", 32'(bus.res_out.rd_tag), 32'(e.tag));
      chk("src1_valid", 32'(bus.res_out.src1_valid), 32'(e.s1v));
      if (e.s1v) chk("src1_data", bus.res_out.src1_data, e.s1x);
      else       chk("src1_tag", 32'(bus.res_out.src1_tag), e.s1x);
      chk("src2_valid", 32'(bus.res_out.src2_valid), 32'(e.s2v));
      if (e.s2v) chk("src2_data", bus.res_out.src2_data, e.s2x);
      else       chk("src2_tag", 32'(bus.res_out.src2_tag), e.s2x);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   c;
    bit   seen;
    e.lw  = v.exp_lw;
    e.cyc = v.exp_cyc;
    e.tag = v.rob_tag;
    e.s1v = v.e_s1v;
    e.s1x = v.e_s1v ? v.e_s1d : 32'(v.r1_tag);
    e.s2v = v.e_s2v;
    e.s2x = v.e_s2v ? v.e_s2d : 32'(v.r2_tag);
    sb_q.push_back(e);
    set_word(v.rs1, v.rs2, v.use_imm, v.imm);
    bus.rs1_ready = v.r1_rdy;
    bus.rs1_tag   = v.r1_tag;
    bus.rs1_data  = v.r1_data;
    bus.rs2_ready = v.r2_rdy;
    bus.rs2_tag   = v.r2_tag;
    bus.rs2_data  = v.r2_data;
    if (v.calc != 8'h00) bus.cdb[v.cdb_tag].data = v.cdb_val;
    c    = 0;
    seen = 1'b0;
    while (!seen && c < 24) begin
      bus.iq_valid        = (c == 0);
      bus.rob_alloc_ack   = (c >= 1);
      bus.rob_tag         = v.rob_tag;
      bus.robs_calculated = (c >= int'(v.calc_cyc)) ? v.calc : 8'h00;
      bus.res_empty       = (c >= int'(v.empty_cyc)) ? v.empty : 4'h0;
      #1;
      if (c == 0) chk("iq_ready_accept", 32'(bus.iq_ready), 32'd1);
      if (c == 1) chk("alloc_req", 32'(bus.rob_alloc_req), 32'd1);
      if (bus.load_word != 4'h0) begin
        seen = 1'b1;
        check_strobe(c);
      end
      step();
      c++;
    end
    if (!seen) begin
      n_chk++;
      n_err++;
      $display("FAIL strobe_timeout: got none expected %0h", v.exp_lw);
      void'(sb_q.pop_front());
    end
    idle_inputs();
    #1;
    chk("post_strobe_lw", 32'(bus.load_word), 32'd0);
    chk("post_strobe_ready", 32'(bus.iq_ready), 32'd1);
    step();
  endtask

  initial begin
    // rs1 rs2 imm? imm | r1 rdy/tag/data | r2 rdy/tag/data | rob | calc/cyc/tag/val |
    // empty/cyc | exp lw/cyc | s1 v/d | s2 v/d
    vecs[0] = '{5'd1, 5'd2, 1'b0, 32'h0, 1'b1, 3'd0, 32'd5, 1'b1, 3'd0, 32'd7, 3'd5,
                8'h00, 8'd0, 3'd0, 32'h0, 4'b1111, 8'd0, 4'b0001, 8'd3,
                1'b1, 32'd5, 1'b1, 32'd7};
    vecs[1] = '{5'd1, 5'd2, 1'b0, 32'h0, 1'b0, 3'd2, 32'h5555, 1'b1, 3'd0, 32'd9, 3'd1,
                8'h04, 8'd4, 3'd2, 32'h1234, 4'b0001, 8'd4, 4'b0001, 8'd4,
                1'b1, 32'h1234, 1'b1, 32'd9};
    vecs[2] = '{5'd3, 5'd4, 1'b0, 32'h0, 1'b1, 3'd0, 32'd3, 1'b1, 3'd0, 32'd4, 3'd7,
                8'h00, 8'd0, 3'd0, 32'h0, 4'b0110, 8'd8, 4'b0010, 8'd8,
                1'b1, 32'd3, 1'b1, 32'd4};
    vecs[3] = '{5'd0, 5'd5, 1'b1, 32'hFFFF_FFFF, 1'b1, 3'd0, 32'hBAD1, 1'b0, 3'd3, 32'h0,
                3'd4, 8'h08, 8'd0, 3'd3, 32'h7777, 4'b1000, 8'd0, 4'b1000, 8'd3,
                1'b1, 32'd0, 1'b1, 32'hFFFF_FFFF};
    vecs[4] = '{5'd6, 5'd7, 1'b0, 32'h0, 1'b0, 3'd6, 32'h0, 1'b1, 3'd0, 32'h11, 3'd2,
                8'h40, 8'd2, 3'd6, 32'hABCD, 4'b0100, 8'd0, 4'b0100, 8'd3,
                1'b1, 32'hABCD, 1'b1, 32'h11};
    vecs[5] = '{5'd8, 5'd9, 1'b0, 32'h0, 1'b1, 3'd0, 32'h22, 1'b0, 3'd4, 32'h0, 3'd3,
                8'h00, 8'd0, 3'd0, 32'h0, 4'b1010, 8'd0, 4'b0010, 8'd3,
                1'b1, 32'h22, 1'b0, 32'h0};
    vecs[6] = '{5'd0, 5'd0, 1'b0, 32'h0, 1'b0, 3'd1, 32'h99, 1'b0, 3'd2, 32'h98, 3'd6,
                8'h00, 8'd0, 3'd0, 32'h0, 4'b1111, 8'd0, 4'b0001, 8'd3,
                1'b1, 32'd0, 1'b1, 32'd0};

    // Reset state.
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_iq_ready", 32'(bus.iq_ready), 32'd1);
    chk("rst_load_word", 32'(bus.load_word), 32'd0);
    chk("rst_alloc_req", 32'(bus.rob_alloc_req), 32'd0);
    chk("rst_op", 32'(bus.res_out.op), 32'(BRANCH));
    chk("rst_src1_valid", 32'(bus.res_out.src1_valid), 32'd0);
    chk("rst_src2_valid", 32'(bus.res_out.src2_valid), 32'd0);
    step();

    foreach (vecs[i]) run_vec(vecs[i]);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    // ROB never grants, then flush.
    set_word(5'd1, 5'd2, 1'b0, 32'h0);
    bus.iq_valid  = 1'b1;
    bus.res_empty = 4'b1111;
    #1;
    chk("fl_accept", 32'(bus.iq_ready), 32'd1);
    step();
    bus.iq_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("fl_alloc_req", 32'(bus.rob_alloc_req), 32'd1);
      chk("fl_no_lw", 32'(bus.load_word), 32'd0);
      step();
    end
    flush = 1'b1;
    #1;
    chk("fl_req_gated", 32'(bus.rob_alloc_req), 32'd0);
    chk("fl_lw_gated", 32'(bus.load_word), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_idle_ready", 32'(bus.iq_ready), 32'd1);
    chk("fl_idle_lw", 32'(bus.load_word), 32'd0);
    step();

    // Flush while idle must not accept a valid instruction.
    flush        = 1'b1;
    bus.iq_valid = 1'b1;
    #1;
    chk("fl_idle_no_accept", 32'(bus.iq_ready), 32'd0);
    step();
    flush        = 1'b0;
    bus.iq_valid = 1'b0;
    #1;
    chk("fl_stayed_idle", 32'(bus.rob_alloc_req), 32'd0);
    step();

    // Flush in ISSUE with a free station: no strobe.
    idle_inputs();
    set_word(5'd1, 5'd2, 1'b0, 32'h0);
    bus.rs1_ready = 1'b1;
    bus.rs2_ready = 1'b1;
    bus.iq_valid  = 1'b1;
    step();
    bus.iq_valid      = 1'b0;
    bus.rob_alloc_ack = 1'b1;
    step();
    step();
    flush         = 1'b1;
    bus.res_empty = 4'b1111;
    #1;
    chk("fl_issue_lw", 32'(bus.load_word), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_issue_ready", 32'(bus.iq_ready), 32'd1);
    chk("fl_issue_no_lw", 32'(bus.load_word), 32'd0);
    step();

    // Reset in ISSUE with a free station: no strobe, idle afterwards.
    idle_inputs();
    set_word(5'd1, 5'd2, 1'b0, 32'h0);
    bus.rs1_ready = 1'b1;
    bus.rs1_data  = 32'd5;
    bus.rs2_ready = 1'b1;
    bus.rs2_data  = 32'd6;
    bus.iq_valid  = 1'b1;
    step();
    bus.iq_valid      = 1'b0;
    bus.rob_alloc_ack = 1'b1;
    step();
    step();
    step();
    rst           = 1'b1;
    bus.res_empty = 4'b0001;
    #1;
    chk("rst_issue_lw", 32'(bus.load_word), 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("rst_issue_ready", 32'(bus.iq_ready), 32'd1);
    chk("rst_issue_no_lw", 32'(bus.load_word), 32'd0);
    chk("rst_issue_cleared", 32'(bus.res_out.src1_valid), 32'd0);
    step();
    #1;
    chk("rst_issue_idle", 32'(bus.rob_alloc_req), 32'd0);
    chk("rst_issue_no_lw2", 32'(bus.load_word), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
